mixsx_sched: RTL and testbench
==============================

Name: mixsx_sched

Overview:
- Round-robin scheduler sharing one mixsx32 mixing engine between NREQ requesters.
- Arbitrates and captures a request, then resets and starts the engine. It waits for done (with timeout) and returns cout tagged with the requester id over a valid/ready response channel.
- Sits between the per-core crypto front-ends and the single mixsx32 instance. It owns the engine's reset and enable; the engine cannot restart on its own once it reaches DONE.

Parameters:
- NREQ, 4, number of requesters (>=2).
- CWORDS64, 2, engine C width in 64-bit words; must match the engine.
- XWORDS32, 2, engine X width in 32-bit words; must match the engine.
- IDXW, $clog2(XWORDS32), per-word index width (derived).
- TIMEOUT, 64, maximum WAIT cycles before a job is aborted with error.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NREQ  per-requester request valid
- req_c  in  NREQ*CWORDS64*64  flattened C; slot k at [k*CWORDS64*64 +: CWORDS64*64]
- req_x  in  NREQ*XWORDS32*32  flattened X per slot
- req_d  in  NREQ*CWORDS64*IDXW  flattened D per slot
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NREQ)  id of the requester served
- rsp_cout  out  CWORDS64*64  engine result
- rsp_err  out  1  job timed out
- busy  out  1  job in flight (state != IDLE)
- eng_reset  out  1  engine synchronous reset
- eng_en  out  1  engine start
- eng_c  out  CWORDS64*64  to engine c
- eng_x  out  XWORDS32*32  to engine x
- eng_d  out  CWORDS64*IDXW  to engine d
- eng_cout  in  CWORDS64*64  from engine cout
- eng_done  in  1  from engine done

Interface rule: reset reset, synchronous, active-high; clock clk.

Behaviour:
- Reset values:
  - State IDLE; req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_cout=0, busy=0, eng_en=0.
  - Holding registers (eng_c/x/d) are 0; RR pointer is 0; timeout counter is 0.
  - eng_reset = reset OR (state==CLR), so the engine is held in reset while reset is high.
- IDLE:
  - If any req_valid, grant the first set bit searching from ptr upward with wrap.
  - Assert req_ready[winner] combinationally this cycle (one-hot, only in IDLE).
  - Capture that slot's c/x/d into the holding registers and record the winner id.
  - Set ptr = winner+1 mod NREQ, then go to CLR.
- CLR: eng_reset=1 for one cycle (clears the engine's state, iterator and cout); go to START.
- START: eng_en=1 for one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Increment the timeout counter each cycle.
  - If eng_done: rsp_cout <= eng_cout, rsp_err <= 0; go to RESP.
  - Else if counter == TIMEOUT-1: rsp_cout <= 0, rsp_err <= 1; go to RESP.
  - eng_done has priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_cout and rsp_err are held stable.
  - On rsp_valid & rsp_ready: go to IDLE; rsp_valid drops next cycle.
  - A new grant can occur in the first IDLE cycle.
- Holding registers stay stable from CLR through WAIT; the engine samples c/x/d in its INIT cycle.
- Latency (accept cycle = T):
  - CLR at T+1, START at T+2.
  - Engine INIT at T+3, RUN for CWORDS64+1 cycles, eng_done at T+5+CWORDS64.
  - rsp_valid first high at T+6+CWORDS64; this is T+8 at the defaults.
- Requests arriving while busy are not accepted; req_ready stays 0 and requesters hold valid.
- Deasserting req_valid before it is granted is legal; that slot is simply skipped.
- Reset mid-job: everything returns to reset values next cycle, the engine is reset, and no response is emitted.
- busy=1 in CLR, START, WAIT and RESP.

Test Plan:
- Single job, slot 0 only:
  - Stimulus: c=0, x={32'hBBBBBBBB,32'hAAAAAAAA}, d=2'b10.
  - Response: req_ready[0] at T; eng_reset at T+1; eng_en at T+2; rsp_valid at T+8; rsp_id=0, rsp_err=0.
  - rsp_cout=128'h00000000_BBBBBBBB_00000000_AAAAAAAA.
- Round robin: all four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0; each rsp_id matches its grant; one req_ready bit per grant.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_cout stay stable; no req_ready asserted during the stall; the next grant occurs the cycle after the handshake.
- Timeout: eng_done tied 0, TIMEOUT=64 -> rsp_valid at T+3+64 with rsp_err=1 and rsp_cout=0; the next job still runs correctly after a fresh CLR.
- Reset mid-WAIT: pulse reset at T+5 -> no rsp_valid; busy=0 and ptr=0 afterwards; eng_reset is high during reset; a following slot-2 request completes with rsp_id=2.
- Two consecutive jobs from slot 1 with differing d (2'b00, then 2'b11) -> the second result shows no residue of the first; both words are XORed with AAAAAAAA, then both with BBBBBBBB.

Source files
------------

// File: rtl/mixsx_sched.sv
// mixsx_sched: round-robin scheduler sharing one mixsx32 engine between NREQ requesters
module mixsx_sched #(
  parameter int NREQ = 4,
  parameter int CWORDS64 = 2,
  parameter int XWORDS32 = 2,
  parameter int IDXW = $clog2(XWORDS32),
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*CWORDS64*64-1:0]   req_c,
  input  logic [NREQ*XWORDS32*32-1:0]   req_x,
  input  logic [NREQ*CWORDS64*IDXW-1:0] req_d,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [CWORDS64*64-1:0]        rsp_cout,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          eng_reset,
  output logic                          eng_en,
  output logic [CWORDS64*64-1:0]        eng_c,
  output logic [XWORDS32*32-1:0]        eng_x,
  output logic [CWORDS64*IDXW-1:0]      eng_d,
  input  logic [CWORDS64*64-1:0]        eng_cout,
  input  logic                          eng_done
);
  localparam int IW = $clog2(NREQ);
  localparam int CB = CWORDS64*64;
  localparam int XB = XWORDS32*32;
  localparam int DB = CWORDS64*IDXW;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic found;
  logic [CB-1:0] c_q, c_d, c_sel, cout_q, cout_d;
  logic [XB-1:0] x_q, x_d, x_sel;
  logic [DB-1:0] d_q, d_d, d_sel;
  logic [TW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // downward scan so the last hit is the nearest slot at or after ptr
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[IW'((int'(ptr_q) + i) % NREQ)]) begin
        found = 1'b1;
        win = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
    c_sel = '0;
    x_sel = '0;
    d_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        c_sel = req_c[i*CB +: CB];
        x_sel = req_x[i*XB +: XB];
        d_sel = req_d[i*DB +: DB];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    c_d = c_q;
    x_d = x_q;
    d_d = d_q;
    cnt_d = cnt_q;
    cout_d = cout_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = CLR;
        id_d = win;
        c_d = c_sel;
        x_d = x_sel;
        d_d = d_sel;
        ptr_d = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
      end
      CLR: state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (eng_done) begin
          state_d = RESP;
          cout_d = eng_cout;
          err_d = 1'b0;
        end else if (cnt_q == TW'(TIMEOUT-1)) begin
          state_d = RESP;
          cout_d = '0;
          err_d = 1'b1;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      c_q <= '0;
      x_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      cout_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      c_q <= c_d;
      x_q <= x_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      cout_q <= cout_d;
      err_q <= err_d;
    end
  end
  assign req_ready = (state_q == IDLE && found && !reset) ? NREQ'(1) << win : '0;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_cout = cout_q;
  assign rsp_err = err_q;
  assign busy = state_q != IDLE;
  assign eng_reset = reset || state_q == CLR;
  assign eng_en = state_q == START;
  assign eng_c = c_q;
  assign eng_x = x_q;
  assign eng_d = d_q;
endmodule

// File: tb/tb_mixsx_sched.sv
// tb_mixsx_sched: directed vector bench for mixsx_sched with a behavioural mixsx32 stand-in
module tb_mixsx_sched;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid;
  logic [511:0] req_c;
  logic [255:0] req_x;
  logic [7:0] req_d;
  logic [3:0] req_ready;
  logic rsp_valid, rsp_ready, rsp_err, busy, eng_reset, eng_en, eng_done;
  logic [1:0] rsp_id;
  logic [127:0] rsp_cout, eng_c, eng_cout;
  logic [63:0] eng_x;
  logic [1:0] eng_d;
  logic kill_done;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int est = 0;
  typedef struct {
    int slot;
    logic [127:0] c;
    logic [63:0] x;
    logic [1:0] d;
    logic [127:0] cout;
  } vec_t;
  vec_t tv[5];
  mixsx_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_c(req_c), .req_x(req_x),
    .req_d(req_d), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy),
    .eng_reset(eng_reset), .eng_en(eng_en), .eng_c(eng_c), .eng_x(eng_x), .eng_d(eng_d),
    .eng_cout(eng_cout), .eng_done(eng_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [127:0] mix(input logic [127:0] c, input logic [63:0] x, input logic [1:0] d);
    logic [127:0] r;
    for (int k = 0; k < 2; k++) r[k*64 +: 64] = c[k*64 +: 64] ^ {32'h0, d[k] ? x[63:32] : x[31:0]};
    return r;
  endfunction
  // engine stand-in: INIT one cycle after eng_en, three RUN cycles, then DONE until reset
  always @(posedge clk) begin
    if (eng_reset) begin
      est <= 0;
      eng_cout <= '0;
    end else if (eng_en) est <= 1;
    else if (est >= 1 && est <= 4) begin
      est <= est + 1;
      if (est == 4) eng_cout <= mix(eng_c, eng_x, eng_d);
    end
  end
  assign eng_done = (est == 5) && !kill_done;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic set_slot(input int s, input logic [127:0] c, input logic [63:0] x, input logic [1:0] d);
    req_c[s*128 +: 128] = c;
    req_x[s*64 +: 64] = x;
    req_d[s*2 +: 2] = d;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic run_job(input int s, input logic [127:0] c, input logic [63:0] x, input logic [1:0] d,
                         input logic [127:0] ec, input logic ee, input int lat);
    int t, n;
    set_slot(s, c, x, d);
    req_valid[s] = 1'b1;
    @(negedge clk);
    chk("grant", req_ready, 4'b1 << s);
    t = cyc;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    @(negedge clk);
    chk("clr_eng_reset", eng_reset, 1'b1);
    @(negedge clk);
    chk("start_eng_en", eng_en, 1'b1);
    chk("hold_x", eng_x, x);
    wait_rsp(n);
    chk("latency", cyc - t, lat);
    chk("rsp_id", rsp_id, s);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_err", rsp_err, ee);
    @(posedge clk); #1;
  endtask
  initial begin
    int n, t, extra;
    logic [127:0] held_cout;
    tv[0] = '{0, 128'h0, {32'hBBBBBBBB, 32'hAAAAAAAA}, 2'b10, 128'h00000000_BBBBBBBB_00000000_AAAAAAAA};
    tv[1] = '{1, 128'h0, {32'hBBBBBBBB, 32'hAAAAAAAA}, 2'b00, 128'h00000000_AAAAAAAA_00000000_AAAAAAAA};
    tv[2] = '{1, 128'h0, {32'hBBBBBBBB, 32'hAAAAAAAA}, 2'b11, 128'h00000000_BBBBBBBB_00000000_BBBBBBBB};
    tv[3] = '{3, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, {32'h0F0F0F0F, 32'hF0F0F0F0}, 2'b01,
              {64'h1111_2222_C3C3_B4B4, 64'h5555_6666_7878_8787}};
    tv[4] = '{2, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {32'hDEADBEEF, 32'h12345678}, 2'b11,
              {64'hFFFF_FFFF_2152_4110, 64'h0000_0000_DEAD_BEEF}};
    reset = 1'b1;
    req_valid = 4'hF;
    req_c = '0;
    req_x = '0;
    req_d = '0;
    rsp_ready = 1'b1;
    kill_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_cout", rsp_cout, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_eng_en", eng_en, 1'b0);
    chk("rst_eng_reset", eng_reset, 1'b1);
    chk("rst_hold", {eng_c, eng_x, eng_d}, '0);
    @(posedge clk); #1;
    req_valid = 4'h0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_eng_reset", eng_reset, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) run_job(tv[i].slot, tv[i].c, tv[i].x, tv[i].d, tv[i].cout, 1'b0, 8);
    pulse_reset();
    for (int k = 0; k < 4; k++) set_slot(k, tv[0].c, tv[0].x, tv[0].d);
    req_valid = 4'hF;
    extra = 0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, 4'b1 << (g % 4));
      do begin
        @(negedge clk);
        n++;
        if (req_ready !== 4'h0) extra++;
      end while (!rsp_valid && n < 200);
      n = 0;
      chk("rr_id", rsp_id, g % 4);
      @(posedge clk); #1;
      if (g == 4) req_valid = 4'h0;
    end
    chk("rr_no_grant_busy", extra, 0);
    rsp_ready = 1'b0;
    set_slot(0, tv[0].c, tv[0].x, tv[0].d);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_rsp(n);
    held_cout = rsp_cout;
    chk("bp_cout", held_cout, tv[0].cout);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!rsp_valid || rsp_id !== 2'd0 || rsp_cout !== held_cout || req_ready !== 4'h0) extra++;
    end
    chk("bp_stable", extra, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_no_grant", req_ready, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0100);
    t = cyc;
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_rsp(n);
    chk("bp_next_lat", cyc - t, 8);
    chk("bp_next_id", rsp_id, 2'd2);
    @(posedge clk); #1;
    kill_done = 1'b1;
    run_job(3, tv[3].c, tv[3].x, tv[3].d, 128'h0, 1'b1, 67);
    kill_done = 1'b0;
    run_job(0, tv[0].c, tv[0].x, tv[0].d, tv[0].cout, 1'b0, 8);
    set_slot(1, tv[1].c, tv[1].x, tv[1].d);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mr_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_eng_reset", eng_reset, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy, 1'b0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    chk("mr_no_rsp", extra, 0);
    @(posedge clk); #1;
    set_slot(0, tv[0].c, tv[0].x, tv[0].d);
    set_slot(3, tv[3].c, tv[3].x, tv[3].d);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("mr_ptr_zero", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_rsp(n);
    chk("mr_job_cout", rsp_cout, tv[0].cout);
    @(posedge clk); #1;
    run_job(2, tv[4].c, tv[4].x, tv[4].d, tv[4].cout, 1'b0, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
